// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch-to-decode instruction queue with flush and stall
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flushD,
  input  logic             stallD,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic [31:0]      fetch_instr,
  input  logic             fetch_adel,
  output logic             fetch_ready,
  output logic             validD,
  output logic [31:0]      instrD,
  output logic [31:0]      pcD,
  output logic             adelD,
  output logic [PTR_W:0]   countD
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  // Each entry is {adel, pc, instr}
  logic [64:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [64:0]      head;
  logic             push;
  logic             pop;

  // Ready depends only on stored occupancy, so a pop never frees a slot in the same cycle
  assign fetch_ready = (count != FULL);
  assign validD      = (count != '0);
  assign push        = fetch_valid & fetch_ready & ~flushD;
  assign pop         = validD & ~stallD & ~flushD;
  assign countD      = count;

  // An empty queue presents a NOP with no exception flag to the decoder
  assign head   = mem[rd_ptr];
  assign instrD = validD ? head[31:0]  : 32'h0000_0000;
  assign pcD    = validD ? head[63:32] : 32'h0000_0000;
  assign adelD  = validD ? head[64]    : 1'b0;

  // Pointer and occupancy update; flush wins over any push or pop in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flushD) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array is write-only on push and deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {fetch_adel, fetch_pc, fetch_instr};
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - randomized self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             resetn;
  logic             flushD;
  logic             stallD;
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_instr;
  logic             fetch_adel;
  logic             fetch_ready;
  logic             validD;
  logic [31:0]      instrD;
  logic [31:0]      pcD;
  logic             adelD;
  logic [PTR_W:0]   countD;

  int checks   = 0;
  int failures = 0;

  // Reference model: an ordinary FIFO of {adel, pc, instr}
  logic [64:0] q[$];

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk),
    .resetn(resetn),
    .flushD(flushD),
    .stallD(stallD),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr),
    .fetch_adel(fetch_adel),
    .fetch_ready(fetch_ready),
    .validD(validD),
    .instrD(instrD),
    .pcD(pcD),
    .adelD(adelD),
    .countD(countD)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [64:0] h;
    h = (q.size() != 0) ? q[0] : 65'd0;
    check("validD", 64'(validD), 64'(q.size() != 0));
    check("instrD", 64'(instrD), 64'(h[31:0]));
    check("pcD", 64'(pcD), 64'(h[63:32]));
    check("adelD", 64'(adelD), 64'(h[64]));
    check("countD", 64'(countD), 64'(q.size()));
    check("fetch_ready", 64'(fetch_ready), 64'(q.size() != DEPTH));
  endtask

  // Called at a falling edge: drive, advance one rising edge, update model, check at next falling edge
  task automatic step(input logic fl, input logic st, input logic fv,
                      input logic [31:0] pc, input logic [31:0] ins, input logic ad,
                      output logic accepted);
    logic pp;
    flushD      = fl;
    stallD      = st;
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = ins;
    fetch_adel  = ad;
    @(posedge clk);
    accepted = fv && (q.size() != DEPTH) && !fl;
    pp       = (q.size() != 0) && !st && !fl;
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (accepted) q.push_back({ad, pc, ins});
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic        acc;
    logic        got;
    logic [31:0] pc;
    logic [31:0] prev_pc;

    resetn = 1'b0;
    flushD = 1'b0;
    stallD = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc = '0;
    fetch_instr = '0;
    fetch_adel = 1'b0;
    @(negedge clk);
    check_outputs();
    resetn = 1'b1;

    // Single push, 1-cycle latency, then pop
    step(0, 0, 1, 32'hBFC0_0000, 32'h2408_0001, 0, acc);
    check("t1_instr", 64'(instrD), 64'h2408_0001);
    check("t1_pc", 64'(pcD), 64'hBFC0_0000);
    step(0, 0, 0, 32'h0, 32'h0, 0, acc);
    check("t1_empty_instr", 64'(instrD), 64'h0);

    // Stalled fill: fifth word refused
    for (int i = 0; i < 5; i++)
      step(0, 1, 1, 32'hBFC0_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 0, acc);
    check("t2_count", 64'(countD), 64'd4);
    check("t2_ready", 64'(fetch_ready), 64'd0);
    check("t2_head", 64'(pcD), 64'hBFC0_0000);

    // Release stall, fifth word retried until accepted, then drain in order
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      step(0, 0, 1, 32'hBFC0_0010, 32'h1000_0004, 0, acc);
      got = acc;
    end
    check("t3_accepted", 64'(got), 64'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 32'h0, 0, acc);

    // Flush with 3 entries and a concurrent push
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 32'hBFC0_0020 + 32'(4 * i), 32'h2000_0000 + 32'(i), 0, acc);
    step(1, 0, 1, 32'hBFC0_0FFC, 32'hDEAD_BEEF, 0, acc);
    check("t4_count", 64'(countD), 64'd0);
    step(0, 1, 1, 32'hBFC0_0100, 32'h3000_0000, 0, acc);
    check("t4_head", 64'(pcD), 64'hBFC0_0100);

    // Steady push+pop at count 2 across pointer wrap
    step(0, 1, 1, 32'hBFC0_0104, 32'h3000_0001, 0, acc);
    pc = 32'hBFC0_0108;
    prev_pc = pcD;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, pc, 32'h3000_0002 + 32'(i), 0, acc);
      pc += 32'd4;
      check("t5_count", 64'(countD), 64'd2);
      check("t5_contig", 64'(pcD), 64'(prev_pc + 32'd4));
      prev_pc = pcD;
    end

    // Exception flag, then asynchronous reset mid-cycle
    step(1, 0, 0, 32'h0, 32'h0, 0, acc);
    step(0, 1, 1, 32'hBFC0_0003, 32'h0000_000C, 1, acc);
    check("t6_adel", 64'(adelD), 64'd1);
    check("t6_pc", 64'(pcD), 64'hBFC0_0003);
    fetch_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    q.delete();
    check("t6_rst_valid", 64'(validD), 64'd0);
    check("t6_rst_count", 64'(countD), 64'd0);
    check("t6_rst_ready", 64'(fetch_ready), 64'd1);
    @(negedge clk);
    check_outputs();
    resetn = 1'b1;

    // Randomized traffic
    pc = 32'h8000_0000;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 7), pc, $urandom, 1'($urandom_range(0, 7) == 0), acc);
      if (acc) pc += 32'd4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
